// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and bus widths for the IFU/LSU memory arbiter.
// Optional round-robin arbitration is selected with YSYX_23060251_ARB_RR_EN.
package mem_arbiter_pkg;

  // Bus widths shared with the rest of the ysyx_23060251 core.
  localparam int unsigned XLEN       = 32;
  localparam int unsigned RAM_ADDR_W = 32;
  localparam int unsigned RAM_DATA_W = XLEN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational 2-way grant between IFU and LSU: fixed LSU priority, or
// round-robin on ties when YSYX_23060251_ARB_RR_EN is defined.
module mem_arbiter_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic enable,
  input  logic ifu_valid,
  input  logic lsu_valid,
`ifdef YSYX_23060251_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_ifu,
  output logic grant_lsu
);

  logic pick_lsu;

  // NOTE: pick_lsu gets a default before any condition so no latch is inferred.
  always_comb begin
    pick_lsu = lsu_valid;
`ifdef YSYX_23060251_ARB_RR_EN
    if (ifu_valid && lsu_valid) begin
      pick_lsu = (last_grant == OWN_IFU);
    end
`endif
  end

  assign grant_lsu = enable & lsu_valid & pick_lsu;
  assign grant_ifu = enable & ifu_valid & ~pick_lsu;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the IFU and LSU with a transaction watchdog.
// Define YSYX_23060251_ARB_RR_EN for round-robin tie breaking.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = RAM_ADDR_W,
  parameter int unsigned DATA_W         = RAM_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ifu_req_valid_i,
  output logic                ifu_req_ready_o,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_resp_valid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  output logic                ifu_resp_err_o,
  input  logic                lsu_req_valid_i,
  output logic                lsu_req_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_wen_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  output logic                lsu_resp_valid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_resp_err_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_resp_valid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_resp_err_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic                owner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  logic grant_ifu, grant_lsu, grant;
  logic timeout, resp_real, resp_tout, resp_fire, resp_err;
  logic [DATA_W-1:0] resp_data;

`ifdef YSYX_23060251_ARB_RR_EN
  logic last_grant_q;
`endif

  mem_arbiter_arb_pick u_arb_pick (
    .enable     (state_q == ST_IDLE && !rst_i),
    .ifu_valid  (ifu_req_valid_i),
    .lsu_valid  (lsu_req_valid_i),
`ifdef YSYX_23060251_ARB_RR_EN
    .last_grant (last_grant_q),
`endif
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  assign grant           = grant_ifu | grant_lsu;
  assign ifu_req_ready_o = grant_ifu;
  assign lsu_req_ready_o = grant_lsu;

  // A real accept/response always wins over a coincident timeout.
  assign timeout   = (cnt_q == CNT_LAST);
  assign resp_real = !rst_i && state_q == ST_WAIT && mem_resp_valid_i;
  assign resp_tout = !rst_i && timeout &&
                     ((state_q == ST_REQ  && !mem_req_ready_i) ||
                      (state_q == ST_WAIT && !mem_resp_valid_i));
  assign resp_fire = resp_real | resp_tout;
  assign resp_err  = resp_real ? mem_resp_err_i : 1'b1;
  assign resp_data = resp_real ? mem_rdata_i : '0;

  assign ifu_resp_valid_o = resp_fire && owner_q == OWN_IFU;
  assign ifu_resp_err_o   = ifu_resp_valid_o & resp_err;
  assign ifu_rdata_o      = ifu_resp_valid_o ? resp_data : '0;
  assign lsu_resp_valid_o = resp_fire && owner_q == OWN_LSU;
  assign lsu_resp_err_o   = lsu_resp_valid_o & resp_err;
  assign lsu_rdata_o      = lsu_resp_valid_o ? resp_data : '0;

  assign mem_req_valid_o = !rst_i && state_q == ST_REQ;
  assign mem_addr_o      = addr_q;
  assign mem_wen_o       = wen_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_req_ready_i) state_d = ST_WAIT;
        else if (timeout)    state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (mem_resp_valid_i) state_d = ST_IDLE;
        else if (timeout)     state_d = ST_DRAIN;
      end
      ST_DRAIN: if (mem_resp_valid_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the latched payload is reset as well, because it drives mem_* outputs directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_lsu ? OWN_LSU : OWN_IFU;
        cnt_q   <= '0;
        addr_q  <= grant_lsu ? lsu_addr_i : ifu_addr_i;
        wen_q   <= grant_lsu & lsu_wen_i;
        wdata_q <= grant_lsu ? lsu_wdata_i : '0;
        wmask_q <= grant_lsu ? lsu_wmask_i : '0;
      end else if ((state_q == ST_REQ || state_q == ST_WAIT) && !timeout) begin
        // Saturates so a WAIT entered on the last cycle still times out.
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef YSYX_23060251_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= OWN_IFU;
    end else if (grant) begin
      last_grant_q <= grant_lsu ? OWN_LSU : OWN_IFU;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with an 8-cycle watchdog.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ifu_req_valid_i, ifu_req_ready_o;
  logic [31:0] ifu_addr_i;
  logic        ifu_resp_valid_o, ifu_resp_err_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [3:0]  lsu_wmask_i;
  logic        lsu_resp_valid_o, lsu_resp_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_resp_valid_i, mem_resp_err_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_ifu2;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_addr_i(ifu_addr_i), .ifu_resp_valid_o(ifu_resp_valid_o),
    .ifu_rdata_o(ifu_rdata_o), .ifu_resp_err_o(ifu_resp_err_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wmask_i(lsu_wmask_i), .lsu_resp_valid_o(lsu_resp_valid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_resp_err_o(lsu_resp_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_rdata_i(mem_rdata_i), .mem_resp_err_i(mem_resp_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    ifu_req_valid_i = 1'b1; ifu_addr_i = '0;
    lsu_req_valid_i = 1'b0; lsu_addr_i = '0; lsu_wen_i = 1'b0;
    lsu_wdata_i = '0; lsu_wmask_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    mem_rdata_i = '0; mem_resp_err_i = 1'b0;
    step(); step(); #1;
    check("rst_ifu_ready", 32'(ifu_req_ready_o), 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_resp", 32'({ifu_resp_valid_o, lsu_resp_valid_o, ifu_resp_err_o, lsu_resp_err_o}), 32'd0);

    // Single IFU read: accept at +1, response at +3.
    step(); rst_i = 1'b0; ifu_addr_i = 32'h8000_0000; #1;
    check("t1_ifu_ready", 32'(ifu_req_ready_o), 32'd1);
    check("t1_lsu_ready", 32'(lsu_req_ready_o), 32'd0);
    check("t1_mem_valid_idle", 32'(mem_req_valid_o), 32'd0);
    step(); ifu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
    check("t1_mem_valid", 32'(mem_req_valid_o), 32'd1);
    check("t1_mem_addr", mem_addr_o, 32'h8000_0000);
    check("t1_mem_wen", 32'(mem_wen_o), 32'd0);
    check("t1_mem_wmask", 32'(mem_wmask_o), 32'd0);
    step(); mem_req_ready_i = 1'b0; #1;
    check("t1_wait_no_valid", 32'(mem_req_valid_o), 32'd0);
    check("t1_wait_no_resp", 32'(ifu_resp_valid_o), 32'd0);
    step(); mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h0000_0413; #1;
    check("t1_resp_valid", 32'(ifu_resp_valid_o), 32'd1);
    check("t1_rdata", ifu_rdata_o, 32'h0000_0413);
    check("t1_err", 32'(ifu_resp_err_o), 32'd0);
    check("t1_lsu_quiet", 32'(lsu_resp_valid_o), 32'd0);
    check("t1_lsu_rdata", lsu_rdata_o, 32'd0);
    step(); mem_resp_valid_i = 1'b0; mem_rdata_i = '0; #1;
    check("t1_pulse_end", 32'(ifu_resp_valid_o), 32'd0);

    // Tie: LSU store wins first.
    step();
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0004;
    lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_1000; lsu_wen_i = 1'b1;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF; #1;
    check("t2_lsu_ready", 32'(lsu_req_ready_o), 32'd1);
    check("t2_ifu_ready", 32'(ifu_req_ready_o), 32'd0);
    step(); lsu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
    check("t2_mem_addr", mem_addr_o, 32'h8000_1000);
    check("t2_mem_wen", 32'(mem_wen_o), 32'd1);
    check("t2_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check("t2_mem_wmask", 32'(mem_wmask_o), 32'hF);
    check("t2_req_ifu_ready", 32'(ifu_req_ready_o), 32'd0);
    step(); mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; #1;
    check("t2_lsu_resp", 32'(lsu_resp_valid_o), 32'd1);
    check("t2_ifu_no_resp", 32'(ifu_resp_valid_o), 32'd0);

    // Second tie: round-robin hands it to IFU, fixed priority keeps LSU.
`ifdef YSYX_23060251_ARB_RR_EN
    exp_ifu2 = 1'b1;
`else
    exp_ifu2 = 1'b0;
`endif
    step();
    mem_resp_valid_i = 1'b0;
    lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_2000; lsu_wen_i = 1'b0;
    lsu_wdata_i = '0; lsu_wmask_i = '0; #1;
    check("t2b_ifu_ready", 32'(ifu_req_ready_o), 32'(exp_ifu2));
    check("t2b_lsu_ready", 32'(lsu_req_ready_o), 32'(!exp_ifu2));
    step();
    if (exp_ifu2) ifu_req_valid_i = 1'b0; else lsu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1; #1;
    check("t2b_mem_addr", mem_addr_o, exp_ifu2 ? 32'h8000_0004 : 32'h8000_2000);
    step(); mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h1111_1111; #1;
    check("t2b_ifu_resp", 32'(ifu_resp_valid_o), 32'(exp_ifu2));
    check("t2b_lsu_resp", 32'(lsu_resp_valid_o), 32'(!exp_ifu2));
    step(); mem_resp_valid_i = 1'b0; #1;
    check("t2c_ifu_ready", 32'(ifu_req_ready_o), 32'(!exp_ifu2));
    check("t2c_lsu_ready", 32'(lsu_req_ready_o), 32'(exp_ifu2));
    step(); ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
    check("t2c_mem_addr", mem_addr_o, exp_ifu2 ? 32'h8000_2000 : 32'h8000_0004);
    step(); mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h2222_2222; #1;
    check("t2c_ifu_resp", 32'(ifu_resp_valid_o), 32'(!exp_ifu2));
    check("t2c_rdata", exp_ifu2 ? lsu_rdata_o : ifu_rdata_o, 32'h2222_2222);
    step(); mem_resp_valid_i = 1'b0; mem_rdata_i = '0; #1;

    // Backpressure: 5 cycles without accept, payload stable, no master ready.
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0100; #1;
    check("t3_ifu_ready", 32'(ifu_req_ready_o), 32'd1);
    step(); ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_3000; #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_bp_valid", 32'(mem_req_valid_o), 32'd1);
      check("t3_bp_addr", mem_addr_o, 32'h8000_0100);
      check("t3_bp_wen", 32'(mem_wen_o), 32'd0);
      check("t3_bp_lsu_ready", 32'(lsu_req_ready_o), 32'd0);
      step(); #1;
    end
    mem_req_ready_i = 1'b1; #1;
    check("t3_accept_valid", 32'(mem_req_valid_o), 32'd1);
    step(); mem_req_ready_i = 1'b0; lsu_req_valid_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h3333_3333; #1;
    check("t3_resp", 32'(ifu_resp_valid_o), 32'd1);
    check("t3_rdata", ifu_rdata_o, 32'h3333_3333);
    step(); mem_resp_valid_i = 1'b0; mem_rdata_i = '0; #1;

    // Timeout in WAIT: error on the 8th REQ+WAIT cycle, then DRAIN.
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0200; #1;
    check("t4_ifu_ready", 32'(ifu_req_ready_o), 32'd1);
    step(); ifu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; #1;
    step(); mem_req_ready_i = 1'b0; #1;
    for (int k = 1; k < 7; k++) begin
      check("t4_no_early_resp", 32'(ifu_resp_valid_o), 32'd0);
      step(); #1;
    end
    check("t4_tout_valid", 32'(ifu_resp_valid_o), 32'd1);
    check("t4_tout_err", 32'(ifu_resp_err_o), 32'd1);
    check("t4_tout_rdata", ifu_rdata_o, 32'd0);
    step(); lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_4000; lsu_wen_i = 1'b0; #1;
    check("t4_drain_lsu_ready", 32'(lsu_req_ready_o), 32'd0);
    check("t4_drain_mem_valid", 32'(mem_req_valid_o), 32'd0);
    check("t4_drain_no_resp", 32'(ifu_resp_valid_o), 32'd0);
    step(); mem_resp_valid_i = 1'b1; #1;
    check("t4_late_ifu", 32'(ifu_resp_valid_o), 32'd0);
    check("t4_late_lsu", 32'(lsu_resp_valid_o), 32'd0);
    check("t4_late_ready", 32'(lsu_req_ready_o), 32'd0);
    step(); mem_resp_valid_i = 1'b0; mem_rdata_i = '0; #1;
    check("t4_back_idle", 32'(lsu_req_ready_o), 32'd1);

    // Response coincident with the last counter cycle wins.
    step(); lsu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
    check("t5_mem_addr", mem_addr_o, 32'h8000_4000);
    step(); mem_req_ready_i = 1'b0; #1;
    for (int k = 1; k < 7; k++) begin
      check("t5_no_early_resp", 32'(lsu_resp_valid_o), 32'd0);
      step(); #1;
    end
    mem_resp_valid_i = 1'b1; mem_resp_err_i = 1'b1; mem_rdata_i = 32'h0000_1234; #1;
    check("t5_resp", 32'(lsu_resp_valid_o), 32'd1);
    check("t5_err", 32'(lsu_resp_err_o), 32'd1);
    check("t5_rdata", lsu_rdata_o, 32'h0000_1234);
    step(); mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0; mem_rdata_i = '0;
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0300; #1;
    check("t5_idle_not_drain", 32'(ifu_req_ready_o), 32'd1);

    // Timeout in REQ: error pulse, then mem_req_valid_o drops.
    step(); ifu_req_valid_i = 1'b0; #1;
    for (int k = 0; k < 7; k++) begin
      check("t6_req_valid", 32'(mem_req_valid_o), 32'd1);
      check("t6_no_early_resp", 32'(ifu_resp_valid_o), 32'd0);
      step(); #1;
    end
    check("t6_tout_valid", 32'(ifu_resp_valid_o), 32'd1);
    check("t6_tout_err", 32'(ifu_resp_err_o), 32'd1);
    step(); #1;
    check("t6_req_dropped", 32'(mem_req_valid_o), 32'd0);
    check("t6_no_resp", 32'(ifu_resp_valid_o), 32'd0);

    // Reset in WAIT: back to IDLE, later response ignored.
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0400; #1;
    check("t7_ifu_ready", 32'(ifu_req_ready_o), 32'd1);
    step(); ifu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
    step(); mem_req_ready_i = 1'b0; rst_i = 1'b1; #1;
    check("t7_rst_mem_valid", 32'(mem_req_valid_o), 32'd0);
    step(); rst_i = 1'b0; #1;
    check("t7_idle_mem_valid", 32'(mem_req_valid_o), 32'd0);
    check("t7_addr_cleared", mem_addr_o, 32'd0);
    check("t7_no_resp", 32'({ifu_resp_valid_o, lsu_resp_valid_o}), 32'd0);
    mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h5555_5555; #1;
    check("t7_stale_ifu", 32'(ifu_resp_valid_o), 32'd0);
    check("t7_stale_lsu", 32'(lsu_resp_valid_o), 32'd0);
    check("t7_stale_rdata", ifu_rdata_o, 32'd0);
    step(); mem_resp_valid_i = 1'b0; mem_rdata_i = '0; #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
